ssd_scan_driver: RTL and testbench

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

---
 rtl/ssd_scan_driver.sv | 195 +++++++++++++++++++
 tb/tb_ssd_scan_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - binary-to-BCD converter feeding a multiplexed seven-segment scan
module ssd_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int BIN_WIDTH    = 13,
    parameter int REFRESH_BITS = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_WIDTH-1:0]  num,
    input  logic                  num_valid,
    input  logic                  signed_mode,
    input  logic                  blank_lz,
    output logic                  num_ready,
    output logic [NUM_DIGITS-1:0] Anode,
    output logic [6:0]            LED_out
);
    localparam int BCD_NIBS = (BIN_WIDTH + 2) / 3;
    localparam int BCD_W    = 4 * BCD_NIBS;
    localparam int EXT_NIBS = (BCD_NIBS > NUM_DIGITS) ? BCD_NIBS : NUM_DIGITS;
    localparam int EXT_W    = 4 * EXT_NIBS;
    localparam int CNT_W    = $clog2(BIN_WIDTH);
    localparam int IDX_W    = $clog2(NUM_DIGITS);

    localparam logic [6:0] GLYPH_E     = 7'b0110000;
    localparam logic [6:0] GLYPH_MINUS = 7'b1111110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0]       mag_q, mag_d;
    logic [BCD_W-1:0]           bcd_q, bcd_d, bcd_adj;
    logic                       neg_pend_q, neg_pend_d, blank_pend_q, blank_pend_d;
    logic [NUM_DIGITS-1:0][3:0] disp_dig_q, disp_dig_d, commit_dig;
    logic                       disp_neg_q, disp_neg_d, disp_blank_q, disp_blank_d;
    logic                       disp_ovf_q, disp_ovf_d, commit_ovf;
    logic [REFRESH_BITS-1:0]    ref_q, ref_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_DIGITS-1:0]      anode_q, anode_d;
    logic [6:0]                 led_q, led_d;
    logic [EXT_W-1:0]           bcd_ext;
    logic                       accept, accept_neg, conv_last, zero_run;
    logic [3:0]                 cur_dig;
    int                         lz_pos;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b0000001;
            4'd1: seg7 = 7'b1001111;
            4'd2: seg7 = 7'b0010010;
            4'd3: seg7 = 7'b0000110;
            4'd4: seg7 = 7'b1001100;
            4'd5: seg7 = 7'b0100100;
            4'd6: seg7 = 7'b0100000;
            4'd7: seg7 = 7'b0001111;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0000100;
            default: seg7 = GLYPH_BLANK;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (num_valid) state_d = S_CONV;
            S_CONV:   if (conv_last) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        num_ready = (state_q == S_IDLE);
    end

    assign accept     = num_valid & num_ready;
    assign accept_neg = signed_mode & num[BIN_WIDTH-1];
    assign conv_last  = (state_q == S_CONV) && (cnt_q == CNT_W'(BIN_WIDTH - 1));

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_NIBS; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    always_comb begin
        cnt_d        = cnt_q;
        mag_d        = mag_q;
        bcd_d        = bcd_q;
        neg_pend_d   = neg_pend_q;
        blank_pend_d = blank_pend_q;
        if (accept) begin
            cnt_d        = '0;
            mag_d        = accept_neg ? (~num + BIN_WIDTH'(1)) : num;
            bcd_d        = '0;
            neg_pend_d   = accept_neg;
            blank_pend_d = blank_lz;
        end else if (state_q == S_CONV) begin
            cnt_d = cnt_q + CNT_W'(1);
            // The top BCD bit shifted out is always zero: the register is sized for the full range.
            bcd_d = BCD_W'({bcd_adj, mag_q[BIN_WIDTH-1]});
            mag_d = {mag_q[BIN_WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        bcd_ext    = EXT_W'(bcd_q);
        commit_ovf = 1'b0;
        for (int i = 0; i < EXT_NIBS; i++)
            if (i >= (neg_pend_q ? NUM_DIGITS - 1 : NUM_DIGITS) && bcd_ext[4*i +: 4] != 4'd0)
                commit_ovf = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) commit_dig[i] = bcd_ext[4*i +: 4];
    end

    always_comb begin
        disp_dig_d   = disp_dig_q;
        disp_neg_d   = disp_neg_q;
        disp_blank_d = disp_blank_q;
        disp_ovf_d   = disp_ovf_q;
        if (state_q == S_COMMIT) begin
            disp_dig_d   = commit_dig;
            disp_neg_d   = neg_pend_q;
            disp_blank_d = blank_pend_q;
            disp_ovf_d   = commit_ovf;
        end
    end

    always_comb begin
        ref_d = ref_q + REFRESH_BITS'(1);
        idx_d = idx_q;
        if (ref_q == '1) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        anode_d = ~(NUM_DIGITS'(1) << idx_d);
    end

    // lz_pos is the lowest digit position at and above which every digit is zero.
    always_comb begin
        lz_pos   = NUM_DIGITS;
        zero_run = 1'b1;
        for (int p = NUM_DIGITS - 1; p >= 1; p--) begin
            if (zero_run && disp_dig_q[p] == 4'd0) lz_pos = p;
            else                                   zero_run = 1'b0;
        end
        cur_dig = disp_dig_q[idx_d];
        if (disp_ovf_q)
            led_d = GLYPH_E;
        else if (disp_neg_q && int'(idx_d) == (disp_blank_q ? lz_pos : NUM_DIGITS - 1))
            led_d = GLYPH_MINUS;
        else if (disp_blank_q && int'(idx_d) >= lz_pos)
            led_d = GLYPH_BLANK;
        else
            led_d = seg7(cur_dig);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            mag_q        <= '0;
            bcd_q        <= '0;
            neg_pend_q   <= 1'b0;
            blank_pend_q <= 1'b1;
            disp_dig_q   <= '0;
            disp_neg_q   <= 1'b0;
            disp_blank_q <= 1'b1;
            disp_ovf_q   <= 1'b0;
            ref_q        <= '0;
            idx_q        <= '0;
            anode_q      <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
            led_q        <= 7'b0000001;
        end else begin
            cnt_q        <= cnt_d;
            mag_q        <= mag_d;
            bcd_q        <= bcd_d;
            neg_pend_q   <= neg_pend_d;
            blank_pend_q <= blank_pend_d;
            disp_dig_q   <= disp_dig_d;
            disp_neg_q   <= disp_neg_d;
            disp_blank_q <= disp_blank_d;
            disp_ovf_q   <= disp_ovf_d;
            ref_q        <= ref_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            led_q        <= led_d;
        end
    end

    assign Anode   = anode_q;
    assign LED_out = led_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - self-checking bench for ssd_scan_driver
module tb_ssd_scan_driver;
    localparam int ND = 4;
    localparam int BW = 13;
    localparam int RB = 2;

    localparam logic [6:0] G_E   = 7'b0110000;
    localparam logic [6:0] G_MIN = 7'b1111110;
    localparam logic [6:0] G_BLK = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] num;
    logic          num_valid, signed_mode, blank_lz;
    logic          num_ready;
    logic [ND-1:0] Anode;
    logic [6:0]    LED_out;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [6:0] got_g [ND];

    typedef struct {
        logic [BW-1:0]     val;
        bit                sgn;
        bit                blz;
        logic [3:0][6:0]   exp;
        string             name;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    ssd_scan_driver #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_BITS(RB)) dut (
        .clk(clk), .rst(rst), .num(num), .num_valid(num_valid),
        .signed_mode(signed_mode), .blank_lz(blank_lz), .num_ready(num_ready),
        .Anode(Anode), .LED_out(LED_out)
    );

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    function automatic logic [6:0] model_glyph(input int val, input bit sgn, input bit blz, input int p);
        bit neg;
        int mag, avail, lim, nd, t, pw, d;
        neg   = sgn && (val >= 4096);
        mag   = neg ? 8192 - val : val;
        avail = neg ? ND - 1 : ND;
        lim   = 1;
        for (int i = 0; i < avail; i++) lim = lim * 10;
        if (mag >= lim) return G_E;
        nd = 1;
        t  = mag / 10;
        while (t > 0) begin nd++; t = t / 10; end
        pw = 1;
        for (int i = 0; i < p; i++) pw = pw * 10;
        d = (mag / pw) % 10;
        if (blz) begin
            if (p < nd) return seg(d);
            if (neg && p == nd) return G_MIN;
            return G_BLK;
        end
        if (neg && p == ND - 1) return G_MIN;
        return seg(d);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, want %0b", name, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!num_ready && k < 100) begin @(negedge clk); k++; end
        if (!num_ready) check({tag, "_ready_timeout"}, 32'(num_ready), 32'd1);
    endtask

    task automatic apply(input logic [BW-1:0] v, input bit s, input bit b);
        wait_ready("apply");
        num = v; signed_mode = s; blank_lz = b; num_valid = 1'b1;
        @(negedge clk);
        num_valid = 1'b0;
    endtask

    task automatic read_display(input int cycles);
        for (int p = 0; p < ND; p++) got_g[p] = 'x;
        repeat (cycles) begin
            @(negedge clk);
            for (int p = 0; p < ND; p++)
                if (Anode == ~(4'b0001 << p)) got_g[p] = LED_out;
        end
    endtask

    task automatic check_display(input string tag, input logic [3:0][6:0] exp);
        @(negedge clk);
        read_display(20);
        for (int p = 0; p < ND; p++) check($sformatf("%s_digit%0d", tag, p), 32'(got_g[p]), 32'(exp[p]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0][6:0] exp;
        int lowc, v;
        bit s, b;

        tbl[0] = '{13'd1234,  1'b0, 1'b0, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, "u1234"};
        tbl[1] = '{13'h1FD6,  1'b1, 1'b1, {G_BLK, G_MIN, 7'b1001100, 7'b0010010}, "s_m42"};
        tbl[2] = '{13'h1000,  1'b1, 1'b0, {G_E, G_E, G_E, G_E}, "s_m4096_ovf"};
        tbl[3] = '{13'd8191,  1'b0, 1'b1, {7'b0000000, 7'b1001111, 7'b0000100, 7'b1001111}, "u8191"};
        tbl[4] = '{13'd0,     1'b0, 1'b1, {G_BLK, G_BLK, G_BLK, 7'b0000001}, "u0_blank"};
        tbl[5] = '{13'h1FFF,  1'b1, 1'b0, {G_MIN, 7'b0000001, 7'b0000001, 7'b1001111}, "s_m1_noblank"};
        tbl[6] = '{13'h1C19,  1'b1, 1'b1, {G_MIN, 7'b0000100, 7'b0000100, 7'b0000100}, "s_m999"};
        tbl[7] = '{13'h1C18,  1'b1, 1'b1, {G_E, G_E, G_E, G_E}, "s_m1000_ovf"};
        tbl[8] = '{13'd105,   1'b0, 1'b1, {G_BLK, 7'b1001111, 7'b0000001, 7'b0100100}, "u105"};
        tbl[9] = '{13'h1FFF,  1'b0, 1'b0, {7'b0000000, 7'b1001111, 7'b0000100, 7'b1001111}, "u8191_msb"};

        rst = 1'b0; num = '0; num_valid = 1'b0; signed_mode = 1'b0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(num_ready), 32'd1);
        check("rst_anode", 32'(Anode), 32'b1110);
        check("rst_led", 32'(LED_out), 32'b0000001);

        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("scan_anode_k%0d", k), 32'(Anode), 32'(4'(~(4'b0001 << ((k / 4) % 4)))));
            check($sformatf("scan_led_k%0d", k), 32'(LED_out), ((k / 4) % 4 == 0) ? 32'b0000001 : 32'(G_BLK));
        end

        wait_ready("lat");
        num = 13'd1234; signed_mode = 1'b0; blank_lz = 1'b0; num_valid = 1'b1;
        @(negedge clk);
        num_valid = 1'b0;
        lowc = 0;
        while (!num_ready && lowc < 100) begin lowc++; @(negedge clk); end
        check("busy_cycles", 32'(lowc), 32'd14);
        check_display("lat_u1234", tbl[0].exp);

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].val, tbl[i].sgn, tbl[i].blz);
            wait_ready(tbl[i].name);
            check_display(tbl[i].name, tbl[i].exp);
        end

        for (int i = 0; i < 24; i++) begin
            v = int'($urandom_range(0, 8191));
            s = 1'($urandom);
            b = 1'($urandom);
            for (int p = 0; p < ND; p++) exp[p] = model_glyph(v, s, b, p);
            apply(13'(v), s, b);
            wait_ready("rand");
            check_display($sformatf("rand%0d_v%0d_s%0d_b%0d", i, v, s, b), exp);
        end

        wait_ready("busy");
        num = 13'd77; signed_mode = 1'b0; blank_lz = 1'b1; num_valid = 1'b1;
        @(negedge clk);
        num = 13'd5;
        wait_ready("busy77");
        @(negedge clk);
        check("hold_accept_first_ready", 32'(num_ready), 32'd0);
        num_valid = 1'b0;
        read_display(12);
        for (int p = 0; p < ND; p++)
            if (got_g[p] !== 7'bx)
                check($sformatf("during_conv_77_digit%0d", p), 32'(got_g[p]),
                      32'((p < 2) ? 7'b0001111 : G_BLK));
        wait_ready("busy5");
        check_display("after_hold_5", {G_BLK, G_BLK, G_BLK, 7'b0100100});

        apply(13'd9999, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("conv_midway_busy", 32'(num_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_ready", 32'(num_ready), 32'd1);
        check("abort_anode", 32'(Anode), 32'b1110);
        check("abort_led", 32'(LED_out), 32'b0000001);
        @(negedge clk);
        rst = 1'b1;
        check_display("abort_disp", {G_BLK, G_BLK, G_BLK, 7'b0000001});
        repeat (30) @(negedge clk);
        check("abort_still_ready", 32'(num_ready), 32'd1);
        check_display("abort_disp_late", {G_BLK, G_BLK, G_BLK, 7'b0000001});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
